aes_inv_core_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 78 +++++++
 rtl/aes_inv_round.sv | 40 ++++
 rtl/aes_inv_core_iter.sv | 106 ++++++++++
 tb/tb_aes_inv_core_iter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-boxes, round constants, GF(2^8) helpers and
// the block/word/FSM types used by the iterative inverse cipher.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {IDLE, RUN} fsm_e;

  localparam byte_t rcon_tbl [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam byte_t sbox_tbl [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam byte_t inv_sbox_tbl [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  function automatic byte_t rcon(input logic [3:0] i);
    return (i >= 4'd1 && i <= 4'd10) ? rcon_tbl[i] : 8'h00;
  endfunction

  function automatic byte_t gf_xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

  // Low bit index of byte r in column c; word0 occupies the top 32 bits.
  function automatic int bpos(input int c, input int r);
    return 120 - 32 * c - 8 * r;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t s,
  input  block_t k,
  input  logic   last,
  output block_t o
);

  block_t sb;
  block_t ark;
  block_t mix;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    sb  = '0;
    mix = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[bpos(c, r) +: 8] = inv_sbox_tbl[s[bpos((c - r + 4) % 4, r) +: 8]];
      end
    end
    ark = sb ^ k;
    for (int c = 0; c < 4; c++) begin
      byte_t a0, a1, a2, a3;
      a0 = ark[bpos(c, 0) +: 8];
      a1 = ark[bpos(c, 1) +: 8];
      a2 = ark[bpos(c, 2) +: 8];
      a3 = ark[bpos(c, 3) +: 8];
      mix[bpos(c, 0) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      mix[bpos(c, 1) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      mix[bpos(c, 2) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      mix[bpos(c, 3) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    o = last ? ark : mix;
  end

endmodule

// File: rtl/aes_inv_core_iter.sv
// Iterative AES-128 decryption: one inverse round per clock, with the key
// schedule walked backwards from the round-10 key.
module aes_inv_core_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] din,
  input  logic [127:0] kin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [127:0] dout
);

  fsm_e       fsm, fsm_d;
  block_t     blk, blk_d;
  block_t     rkey, rkey_d;
  logic [3:0] rnd, rnd_d;
  block_t     dout_d;
  logic       done_d;

  word_t  w0, w1, w2, w3, n0, n1, n2, n3, rot, sub;
  block_t key_next;
  block_t round_out;

  // Key of round rnd derived from the key of round rnd+1.
  always_comb begin
    {w0, w1, w2, w3} = rkey;
    n3  = w3 ^ w2;
    n2  = w2 ^ w1;
    n1  = w1 ^ w0;
    rot = {n3[23:0], n3[31:24]};
    sub = {sbox_tbl[rot[31:24]], sbox_tbl[rot[23:16]], sbox_tbl[rot[15:8]], sbox_tbl[rot[7:0]]};
    n0  = w0 ^ sub ^ {rcon(rnd + 4'd1), 24'h000000};
    key_next = {n0, n1, n2, n3};
  end

  aes_inv_round u_round (
    .s    (blk),
    .k    (key_next),
    .last (rnd == 4'd0),
    .o    (round_out)
  );

  always_comb begin
    fsm_d  = fsm;
    blk_d  = blk;
    rkey_d = rkey;
    rnd_d  = rnd;
    dout_d = dout;
    done_d = 1'b0;
    case (fsm)
      IDLE: begin
        if (start) begin
          blk_d  = din ^ kin;
          rkey_d = kin;
          rnd_d  = 4'(NR - 1);
          fsm_d  = RUN;
        end
      end
      RUN: begin
        if (rnd >= 4'(NR)) begin
          fsm_d = IDLE;
        end else begin
          rkey_d = key_next;
          blk_d  = round_out;
          if (rnd == 4'd0) begin
            dout_d = round_out;
            done_d = 1'b1;
            fsm_d  = IDLE;
          end else begin
            rnd_d = rnd - 4'd1;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm  <= IDLE;
      blk  <= '0;
      rkey <= '0;
      rnd  <= '0;
      dout <= '0;
      done <= 1'b0;
    end else begin
      fsm  <= fsm_d;
      blk  <= blk_d;
      rkey <= rkey_d;
      rnd  <= rnd_d;
      dout <= dout_d;
      done <= done_d;
    end
  end

  assign ready = (fsm == IDLE);
  assign busy  = ~ready;

endmodule

// File: tb/tb_aes_inv_core_iter.sv
// Directed bench for aes_inv_core_iter using FIPS-197 vectors, busy-start,
// back-to-back, mid-run reset and a key-schedule probe.
module tb_aes_inv_core_iter;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] din;
  logic [127:0] kin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [127:0] dout;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] c1_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c1_k  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] c1_pt = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] b_ct  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] b_k   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] b_pt  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] b_k9  = 128'hac7766f319fadc2128d12941575c006e;

  aes_inv_core_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .kin   (kin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until done is seen; 0 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic issue(input logic [127:0] ct, input logic [127:0] key);
    start = 1'b1;
    din   = ct;
    kin   = key;
  endtask

  initial begin
    int  n;
    bit  seen;
    rst   = 1'b1;
    start = 1'b0;
    din   = '0;
    kin   = '0;

    @(negedge clk);
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_busy",  128'(busy),  128'd0);
    check("rst_done",  128'(done),  128'd0);
    check("rst_dout",  dout,        128'd0);
    rst = 1'b0;
    @(negedge clk);

    // C.1: start edge plus ten round edges -> done on the 11th falling edge.
    issue(c1_ct, c1_k);
    wait_done(n);
    check("c1_latency", 128'(n), 128'd11);
    check("c1_dout",    dout,    c1_pt);
    check("c1_ready_in_done", 128'(ready), 128'd1);
    @(negedge clk);
    check("c1_done_pulse", 128'(done), 128'd0);
    check("c1_dout_hold",  dout,        c1_pt);

    // Appendix B with round-key probe after T0 and T1.
    issue(b_ct, b_k);
    @(negedge clk);
    start = 1'b0;
    check("probe_key_t0", dut.rkey, b_k);
    check("busy_t0", 128'(busy), 128'd1);
    @(negedge clk);
    check("probe_key_t1", dut.rkey, b_k9);
    wait_done(n);
    check("b_latency", 128'(n), 128'd9);
    check("b_dout",    dout,    b_pt);

    // Start pulse mid-run must be ignored.
    @(negedge clk);
    issue(c1_ct, c1_k);
    seen = 1'b0;
    n    = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 4) issue(b_ct, b_k);
      else start = 1'b0;
      if (done) begin
        n = k;
        break;
      end
      if (ready) seen = 1'b1;
    end
    start = 1'b0;
    check("busy_start_latency", 128'(n), 128'd11);
    check("busy_start_ready",   128'(seen), 128'd0);
    check("busy_start_dout",    dout, c1_pt);
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("busy_start_single_done", 128'(seen), 128'd0);

    // Back-to-back: new start held in the done cycle.
    issue(c1_ct, c1_k);
    wait_done(n);
    check("b2b_first_latency", 128'(n), 128'd11);
    check("b2b_first_dout",    dout,    c1_pt);
    issue(b_ct, b_k);
    wait_done(n);
    check("b2b_second_gap", 128'(n), 128'd11);
    check("b2b_second_dout", dout,   b_pt);
    @(negedge clk);

    // Reset during a run: no done, cleared outputs, clean restart.
    issue(c1_ct, c1_k);
    seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    rst = 1'b1;
    #1;
    check("midrst_dout",  dout,        128'd0);
    check("midrst_ready", 128'(ready), 128'd1);
    check("midrst_done",  128'(done),  128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", 128'(seen), 128'd0);
    check("midrst_ready_after", 128'(ready), 128'd1);
    issue(b_ct, b_k);
    wait_done(n);
    check("midrst_b_latency", 128'(n), 128'd11);
    check("midrst_b_dout",    dout,    b_pt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
